// File: rtl/cdr_pkg.sv
// Shared types and default constants for the CDR frame receiver.
package cdr_pkg;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        PARITY
    } rx_state_e;

    localparam int unsigned   DEF_SYNC_W      = 8;
    localparam logic [7:0]    DEF_SYNC_WORD   = 8'hA5;
    localparam int unsigned   DEF_DATA_W      = 16;
    localparam int unsigned   DEF_TIMEOUT_CYC = 64;

    // clk cycles per recovered bit on the CDR side
    localparam int unsigned   CDR_CLK_RATIO   = 4;

endpackage

// File: rtl/cdr_sync_det.sv
// Sync-word hunter: serial shift register, saturating bit count and comparator.
module cdr_sync_det #(
    parameter int unsigned        SYNC_W    = 8,
    parameter logic [SYNC_W-1:0]  SYNC_WORD = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_vld,
    input  logic bit_data,
    output logic sync_hit
);

    localparam int unsigned      CNT_W   = $clog2(SYNC_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_W);

    logic [SYNC_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = {shift_q[SYNC_W-2:0], bit_data};
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Hit looks at the post-shift value so the FSM can leave HUNT on the same strobe.
    assign sync_hit = bit_vld && !clr && (cnt_d == CNT_MAX) && (shift_d == SYNC_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (bit_vld) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/cdr_frame_rx.sv
// Frame receiver behind the oversampling CDR: sync hunt, MSB-first payload,
// even parity check and inactivity abort.
module cdr_frame_rx
    import cdr_pkg::*;
#(
    parameter int unsigned        SYNC_W      = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0]  SYNC_WORD   = DEF_SYNC_WORD,
    parameter int unsigned        DATA_W      = DEF_DATA_W,
    parameter int unsigned        TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_vld,
    input  logic              bit_data,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_vld,
    output logic              parity_err,
    output logic              timeout,
    output logic              sync_lock
);

    localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned      CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

    rx_state_e         state_q;
    logic [DATA_W-1:0] payload_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [TMR_W-1:0]  timer_q;
    logic              sync_hit;
    logic              hunt_clr;

    // Holding the hunter cleared outside HUNT gives every frame a fresh sync search.
    assign hunt_clr = (state_q != HUNT);

    cdr_sync_det #(
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_det (
        .clk      (clk),
        .rst      (rst),
        .clr      (hunt_clr),
        .bit_vld  (bit_vld),
        .bit_data (bit_data),
        .sync_hit (sync_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            payload_q  <= '0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            frame_data <= '0;
            frame_vld  <= 1'b0;
            parity_err <= 1'b0;
            timeout    <= 1'b0;
            sync_lock  <= 1'b0;
        end else begin
            frame_vld  <= 1'b0;
            parity_err <= 1'b0;
            timeout    <= 1'b0;
            unique case (state_q)
                HUNT: begin
                    timer_q <= '0;
                    if (sync_hit) begin
                        state_q   <= PAYLOAD;
                        sync_lock <= 1'b1;
                        bit_cnt_q <= '0;
                    end
                end
                PAYLOAD: begin
                    if (bit_vld) begin
                        payload_q <= {payload_q[DATA_W-2:0], bit_data};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        timer_q   <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= PARITY;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        state_q   <= HUNT;
                        sync_lock <= 1'b0;
                        timeout   <= 1'b1;
                        timer_q   <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_vld) begin
                        if ((^payload_q) == bit_data) begin
                            frame_data <= payload_q;
                            frame_vld  <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                        state_q   <= HUNT;
                        sync_lock <= 1'b0;
                        timer_q   <= '0;
                        bit_cnt_q <= '0;
                    end else if (timer_q == TMR_LAST) begin
                        state_q   <= HUNT;
                        sync_lock <= 1'b0;
                        timeout   <= 1'b1;
                        timer_q   <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q   <= HUNT;
                    sync_lock <= 1'b0;
                    timer_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdr_frame_rx.sv
// Directed bench for cdr_frame_rx: good/bad parity, false-sync prefix, timeout,
// back-to-back strobes and mid-frame reset.
module tb_cdr_frame_rx;
    import cdr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_vld = 1'b0;
    logic        bit_data = 1'b0;
    logic [15:0] frame_data;
    logic        frame_vld;
    logic        parity_err;
    logic        timeout;
    logic        sync_lock;

    int checks   = 0;
    int failures = 0;
    int n_vld    = 0;
    int n_perr   = 0;
    int n_tout   = 0;
    int n_lock   = 0;
    int b_vld, b_perr, b_tout, b_lock;

    cdr_frame_rx u_dut (
        .clk        (clk),
        .rst        (rst),
        .bit_vld    (bit_vld),
        .bit_data   (bit_data),
        .frame_data (frame_data),
        .frame_vld  (frame_vld),
        .parity_err (parity_err),
        .timeout    (timeout),
        .sync_lock  (sync_lock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor, sampled 1 time unit after each active edge.
    always @(posedge clk) begin
        #1;
        if (frame_vld === 1'b1)  n_vld++;
        if (parity_err === 1'b1) n_perr++;
        if (timeout === 1'b1)    n_tout++;
        if (sync_lock === 1'b1)  n_lock++;
        if ((frame_vld | parity_err | timeout) === 1'b1) begin
            check("pulse_exclusive", 32'(int'(frame_vld) + int'(parity_err) + int'(timeout)), 32'd1);
        end
    end

    task automatic snap();
        b_vld = n_vld; b_perr = n_perr; b_tout = n_tout; b_lock = n_lock;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One-cycle strobe; returns on the negedge right after the sampling edge.
    task automatic strobe(input logic b);
        bit_vld  = 1'b1;
        bit_data = b;
        @(negedge clk);
        bit_vld  = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] val, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            strobe(val[i]);
            idle(gap - 1);
        end
    endtask

    // Full sync word with the lock checked just before and just after its last bit.
    task automatic send_sync(input string tag, input int gap);
        logic [7:0] sw;
        sw = 8'hA5;
        send_bits(32'(sw[7:1]), 7, gap);
        check({tag, "_lock_pre"}, 32'(sync_lock), 32'd0);
        strobe(sw[0]);
        check({tag, "_lock_post"}, 32'(sync_lock), 32'd1);
        idle(gap - 1);
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        idle(1);
        check("rst_frame_data", 32'(frame_data), 32'h0);
        check("rst_frame_vld", 32'(frame_vld), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_sync_lock", 32'(sync_lock), 32'd0);

        // 1: good frame 0x1234, parity 1, strobe every 4 clk
        snap();
        send_sync("s1", CDR_CLK_RATIO);
        send_bits(32'h1234, 16, CDR_CLK_RATIO);
        check("s1_lock_before_par", 32'(sync_lock), 32'd1);
        strobe(1'b1);
        check("s1_frame_vld", 32'(frame_vld), 32'd1);
        check("s1_frame_data", 32'(frame_data), 32'h1234);
        check("s1_parity_err", 32'(parity_err), 32'd0);
        check("s1_lock_after", 32'(sync_lock), 32'd0);
        idle(1);
        check("s1_vld_pulse_end", 32'(frame_vld), 32'd0);
        idle(2);
        check("s1_vld_count", 32'(n_vld - b_vld), 32'd1);

        // 2: same frame, parity 0
        snap();
        send_sync("s2", CDR_CLK_RATIO);
        send_bits(32'h1234, 16, CDR_CLK_RATIO);
        strobe(1'b0);
        check("s2_parity_err", 32'(parity_err), 32'd1);
        check("s2_frame_vld", 32'(frame_vld), 32'd0);
        check("s2_frame_data_held", 32'(frame_data), 32'h1234);
        check("s2_lock_after", 32'(sync_lock), 32'd0);
        idle(3);
        check("s2_perr_count", 32'(n_perr - b_perr), 32'd1);
        check("s2_vld_count", 32'(n_vld - b_vld), 32'd0);

        // 3: prefix 1011 before sync, payload 0xFFFF parity 0
        snap();
        send_bits(32'hB, 4, CDR_CLK_RATIO);
        check("s3_prefix_nolock", 32'(n_lock - b_lock), 32'd0);
        send_sync("s3", CDR_CLK_RATIO);
        send_bits(32'hFFFF, 16, CDR_CLK_RATIO);
        strobe(1'b0);
        check("s3_frame_vld", 32'(frame_vld), 32'd1);
        check("s3_frame_data", 32'(frame_data), 32'hFFFF);
        idle(3);
        // 3b: 0xA4 repeated must never lock
        snap();
        send_bits(32'hA4A4A4A4, 32, CDR_CLK_RATIO);
        idle(2);
        check("s3b_a4_nolock", 32'(n_lock - b_lock), 32'd0);

        // 4: timeout 64 clk after the last strobe
        snap();
        send_sync("s4", CDR_CLK_RATIO);
        send_bits(32'h15, 4, CDR_CLK_RATIO);
        strobe(1'b1);
        idle(63);
        check("s4_no_timeout_63", 32'(timeout), 32'd0);
        check("s4_lock_63", 32'(sync_lock), 32'd1);
        idle(1);
        check("s4_timeout_64", 32'(timeout), 32'd1);
        check("s4_lock_dropped", 32'(sync_lock), 32'd0);
        check("s4_no_vld", 32'(frame_vld), 32'd0);
        idle(1);
        check("s4_timeout_end", 32'(timeout), 32'd0);
        check("s4_tout_count", 32'(n_tout - b_tout), 32'd1);
        // 4b: strobe lands on the last idle cycle, so no timeout
        snap();
        send_sync("s4b", CDR_CLK_RATIO);
        send_bits(32'h15, 4, CDR_CLK_RATIO);
        strobe(1'b1);
        idle(63);
        strobe(1'b0);
        check("s4b_no_timeout", 32'(timeout), 32'd0);
        check("s4b_lock_held", 32'(sync_lock), 32'd1);
        idle(63);
        check("s4b_tout_none", 32'(n_tout - b_tout), 32'd0);
        idle(1);
        check("s4b_timeout_later", 32'(timeout), 32'd1);
        idle(2);

        // 5: back-to-back strobes, 0xA55A parity 0
        snap();
        send_sync("s5", 1);
        send_bits(32'hA55A, 16, 1);
        strobe(1'b0);
        check("s5_frame_vld", 32'(frame_vld), 32'd1);
        check("s5_frame_data", 32'(frame_data), 32'hA55A);
        check("s5_parity_err", 32'(parity_err), 32'd0);
        idle(3);

        // 6: reset mid-payload, then frame 0x0001 parity 1
        send_sync("s6", CDR_CLK_RATIO);
        send_bits(32'h2D, 6, CDR_CLK_RATIO);
        snap();
        rst = 1'b1;
        #1;
        check("s6_rst_lock", 32'(sync_lock), 32'd0);
        check("s6_rst_frame_data", 32'(frame_data), 32'h0);
        check("s6_rst_frame_vld", 32'(frame_vld), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("s6_no_pulses", 32'((n_vld - b_vld) + (n_perr - b_perr) + (n_tout - b_tout)), 32'd0);
        send_sync("s6b", CDR_CLK_RATIO);
        send_bits(32'h0001, 16, CDR_CLK_RATIO);
        strobe(1'b1);
        check("s6_frame_vld", 32'(frame_vld), 32'd1);
        check("s6_frame_data", 32'(frame_data), 32'h0001);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
